// File: rtl/rob_pkg.sv
// Shared definitions for the re-order buffer: entry classes and tag-width derivation.
package rob_pkg;

  typedef enum logic [1:0] {
    K_NORMAL = 2'd0,
    K_BRANCH = 2'd1,
    K_JALR   = 2'd2,
    K_STORE  = 2'd3
  } kind_e;

  localparam int RD_W = 5;

  // Tag width for a power-of-two depth: smallest w with 2**w >= depth.
  function automatic int idw_f(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/re_order_buffer_v2.sv
// In-order commit buffer: tags issued instructions, collects ALU/LSB writebacks,
// retires one ready head entry per cycle and raises flush/redirect on branch/JALR recovery.
module re_order_buffer_v2
  import rob_pkg::*;
#(
  parameter int  DEPTH       = 16,
  parameter int  XLEN        = 32,
  parameter int  PRED_W      = 5,
  parameter int  FULL_MARGIN = 1,
  localparam int IDW         = idw_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              issue_en,
  input  logic [1:0]        issue_kind,
  input  logic [RD_W-1:0]   issue_rd,
  input  logic [XLEN-1:0]   issue_val,
  input  logic              issue_pred_taken,
  input  logic [PRED_W-1:0] issue_pred_idx,
  output logic [IDW-1:0]    issue_id,
  output logic              full,
  output logic              empty,
  input  logic              wb_alu_en,
  input  logic [IDW-1:0]    wb_alu_id,
  input  logic [XLEN-1:0]   wb_alu_val,
  input  logic [XLEN-1:0]   wb_alu_pc,
  input  logic              wb_alu_taken,
  input  logic              wb_lsb_en,
  input  logic [IDW-1:0]    wb_lsb_id,
  input  logic [XLEN-1:0]   wb_lsb_val,
  input  logic [IDW-1:0]    qry0_id,
  input  logic [IDW-1:0]    qry1_id,
  output logic              qry0_rdy,
  output logic              qry1_rdy,
  output logic [XLEN-1:0]   qry0_val,
  output logic [XLEN-1:0]   qry1_val,
  output logic              commit_en,
  output logic [IDW-1:0]    commit_id,
  output logic [RD_W-1:0]   commit_rd,
  output logic [XLEN-1:0]   commit_val,
  output logic              store_go,
  input  logic              store_done,
  output logic              flush,
  output logic              redirect_en,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              bp_upt_en,
  output logic [PRED_W-1:0] bp_upt_idx,
  output logic              bp_upt_taken
);

  localparam int           CW       = IDW + 1;
  localparam logic [IDW:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [IDW:0] CNT_FULL = CW'(DEPTH - FULL_MARGIN);

  logic [IDW-1:0]    r_head, r_tail;
  logic [IDW:0]      r_count;
  logic [DEPTH-1:0]  r_busy, r_ready, r_taken, r_pred_taken;
  kind_e             r_kind     [DEPTH];
  logic [RD_W-1:0]   r_rd       [DEPTH];
  logic [XLEN-1:0]   r_val      [DEPTH];
  logic [XLEN-1:0]   r_pc       [DEPTH];
  logic [PRED_W-1:0] r_pred_idx [DEPTH];

  logic              r_commit_en, r_flush, r_redirect_en, r_bp_upt_en, r_bp_upt_taken;
  logic [IDW-1:0]    r_commit_id;
  logic [RD_W-1:0]   r_commit_rd;
  logic [XLEN-1:0]   r_commit_val, r_redirect_pc;
  logic [PRED_W-1:0] r_bp_upt_idx;

  logic  w_live, w_issue, w_commit, w_alu_ok, w_lsb_ok, w_store_ok, w_mispred;
  kind_e w_head_kind;

  // Nothing moves while stalled or while the flush pulse is being served.
  assign w_live      = rdy && !r_flush;
  assign w_head_kind = r_kind[r_head];
  assign store_go    = !r_flush && r_busy[r_head] && !r_ready[r_head] && (w_head_kind == K_STORE);
  assign w_issue     = issue_en && w_live && (r_count < CNT_MAX);
  assign w_commit    = w_live && r_busy[r_head] && r_ready[r_head];
  assign w_alu_ok    = wb_alu_en && w_live && r_busy[wb_alu_id] && (r_kind[wb_alu_id] != K_STORE);
  assign w_lsb_ok    = wb_lsb_en && w_live && r_busy[wb_lsb_id] && (r_kind[wb_lsb_id] != K_STORE);
  assign w_store_ok  = store_done && rdy && store_go;
  assign w_mispred   = (w_head_kind == K_JALR) ||
                       ((w_head_kind == K_BRANCH) && (r_taken[r_head] != r_pred_taken[r_head]));

  assign issue_id     = r_tail;
  assign empty        = (r_count == '0);
  assign full         = (r_count >= CNT_FULL);
  assign commit_en    = r_commit_en;
  assign commit_id    = r_commit_id;
  assign commit_rd    = r_commit_rd;
  assign commit_val   = r_commit_val;
  assign flush        = r_flush;
  assign redirect_en  = r_redirect_en;
  assign redirect_pc  = r_redirect_pc;
  assign bp_upt_en    = r_bp_upt_en;
  assign bp_upt_idx   = r_bp_upt_idx;
  assign bp_upt_taken = r_bp_upt_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_busy <= '0; r_ready <= '0;
      r_commit_en <= 1'b0; r_commit_id <= '0; r_commit_rd <= '0; r_commit_val <= '0;
      r_flush <= 1'b0; r_redirect_en <= 1'b0; r_redirect_pc <= '0;
      r_bp_upt_en <= 1'b0; r_bp_upt_idx <= '0; r_bp_upt_taken <= 1'b0;
    end else begin
      r_commit_en   <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_en <= 1'b0;
      r_bp_upt_en   <= 1'b0;
      if (r_flush) begin
        r_head <= '0; r_tail <= '0; r_count <= '0;
        r_busy <= '0; r_ready <= '0;
      end else if (rdy) begin
        if (w_lsb_ok)   r_ready[wb_lsb_id] <= 1'b1;
        if (w_alu_ok)   r_ready[wb_alu_id] <= 1'b1;
        if (w_store_ok) r_ready[r_head]    <= 1'b1;
        // A retiring slot is freed after any writeback that targets it.
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
          r_commit_en     <= 1'b1;
          r_commit_id     <= r_head;
          r_commit_rd     <= r_rd[r_head];
          r_commit_val    <= r_val[r_head];
          if (w_head_kind == K_BRANCH) begin
            r_bp_upt_en    <= 1'b1;
            r_bp_upt_idx   <= r_pred_idx[r_head];
            r_bp_upt_taken <= r_taken[r_head];
          end
          if (w_mispred) begin
            r_flush       <= 1'b1;
            r_redirect_en <= 1'b1;
            r_redirect_pc <= r_pc[r_head];
          end
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + 1'b1;
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload: written only by accepted issue/writeback, never reset.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_kind[r_tail]       <= kind_e'(issue_kind);
      r_rd[r_tail]         <= issue_rd;
      r_val[r_tail]        <= issue_val;
      r_pred_taken[r_tail] <= issue_pred_taken;
      r_pred_idx[r_tail]   <= issue_pred_idx;
    end
    if (w_lsb_ok) r_val[wb_lsb_id] <= wb_lsb_val;
    if (w_alu_ok) begin
      r_val[wb_alu_id]   <= wb_alu_val;
      r_pc[wb_alu_id]    <= wb_alu_pc;
      r_taken[wb_alu_id] <= wb_alu_taken;
    end
  end

  always_comb begin
    qry0_rdy = r_busy[qry0_id] && r_ready[qry0_id];
    qry0_val = r_val[qry0_id];
    qry1_rdy = r_busy[qry1_id] && r_ready[qry1_id];
    qry1_val = r_val[qry1_id];
    if (w_lsb_ok && (wb_lsb_id == qry0_id)) begin qry0_rdy = 1'b1; qry0_val = wb_lsb_val; end
    if (w_alu_ok && (wb_alu_id == qry0_id)) begin qry0_rdy = 1'b1; qry0_val = wb_alu_val; end
    if (w_lsb_ok && (wb_lsb_id == qry1_id)) begin qry1_rdy = 1'b1; qry1_val = wb_lsb_val; end
    if (w_alu_ok && (wb_alu_id == qry1_id)) begin qry1_rdy = 1'b1; qry1_val = wb_alu_val; end
  end

endmodule
